// File: rtl/connect_n_engine.sv
// Connect-N game engine: column-drop moves over valid/ready, turn and legality
// enforcement, one-direction-per-cycle win scan through the placed piece, draw detection.
module connect_n_engine #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   move_valid,
    input  logic [COLS-1:0]        move_col,
    input  logic                   move_player,
    output logic                   move_ready,
    output logic                   turn,
    output logic [ROWS*COLS-1:0]   occupied,
    output logic [ROWS*COLS-1:0]   owner,
    output logic [1:0]             winner,
    output logic                   game_over,
    output logic                   busy,
    output logic                   error,
    output logic [1:0]             error_code
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(CELLS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

    state_t             state_r;
    logic [CELLS-1:0]   occupied_r, owner_r;
    logic [CNT_W-1:0]   move_cnt_r;
    logic [1:0]         dir_r, winner_r, error_code_r;
    logic               win_r, mover_r, turn_r, game_over_r, move_ready_r, busy_r, error_r;
    logic [ROW_W-1:0]   last_row_r, drop_row_s;
    logic [COL_W-1:0]   last_col_r, col_idx_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic               onehot_s, full_s, hit_s;
    int                 dr_s, dc_s;

    // Length of the mover's run through (r0,c0) along (dr,dc), each side clamped to WIN_LEN-1.
    function automatic int run_len(input logic [CELLS-1:0] occ, input logic [CELLS-1:0] own,
                                   input int r0, input int c0, input int dr, input int dc,
                                   input logic p);
        int               run, r, c;
        logic             go;
        logic [IDX_W-1:0] idx;
        run = 1;
        for (int s = 0; s < 2; s++) begin
            go = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                r = (s == 0) ? r0 + k * dr : r0 - k * dr;
                c = (s == 0) ? c0 + k * dc : c0 - k * dc;
                if (go && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                    idx = IDX_W'(r * COLS + c);
                    if (occ[idx] && (own[idx] == p)) run = run + 1;
                    else go = 1'b0;
                end else begin
                    go = 1'b0;
                end
            end
        end
        return run;
    endfunction

    // Decode the requested column and find its landing row.
    always_comb begin
        onehot_s  = (move_col != '0) && ((move_col & (move_col - COLS'(1))) == '0);
        col_idx_s = '0;
        for (int c = 0; c < COLS; c++) begin
            col_idx_s = move_col[c] ? COL_W'(c) : col_idx_s;
        end
        drop_row_s = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            drop_row_s = !occupied_r[IDX_W'(r * COLS + int'(col_idx_s))] ? ROW_W'(r) : drop_row_s;
        end
        full_s    = occupied_r[IDX_W'((ROWS - 1) * COLS + int'(col_idx_s))];
        acc_idx_s = IDX_W'(int'(drop_row_s) * COLS + int'(col_idx_s));
    end

    // Step vector of the direction under test; anti-diagonal climbs to the left.
    always_comb begin
        case (dir_r)
            2'd0:    begin dr_s = 0; dc_s = 1;  end
            2'd1:    begin dr_s = 1; dc_s = 0;  end
            2'd2:    begin dr_s = 1; dc_s = 1;  end
            2'd3:    begin dr_s = 1; dc_s = -1; end
            default: begin dr_s = 0; dc_s = 1;  end
        endcase
        hit_s = run_len(occupied_r, owner_r, int'(last_row_r), int'(last_col_r),
                        dr_s, dc_s, mover_r) >= WIN_LEN;
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            occupied_r   <= '0;
            owner_r      <= '0;
            move_cnt_r   <= '0;
            dir_r        <= 2'd0;
            win_r        <= 1'b0;
            mover_r      <= 1'b0;
            last_row_r   <= '0;
            last_col_r   <= '0;
            turn_r       <= 1'b0;
            winner_r     <= 2'b00;
            game_over_r  <= 1'b0;
            move_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            error_code_r <= 2'b00;
        end else begin
            error_r <= 1'b0;
            if (start) begin
                state_r      <= PLAY;
                occupied_r   <= '0;
                owner_r      <= '0;
                move_cnt_r   <= '0;
                dir_r        <= 2'd0;
                win_r        <= 1'b0;
                turn_r       <= 1'b0;
                winner_r     <= 2'b00;
                game_over_r  <= 1'b0;
                move_ready_r <= 1'b1;
                busy_r       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, DONE: begin
                        if (move_valid) begin
                            error_r      <= 1'b1;
                            error_code_r <= 2'd3;
                        end
                    end
                    PLAY: begin
                        if (move_valid) begin
                            if (!onehot_s) begin
                                error_r      <= 1'b1;
                                error_code_r <= 2'd0;
                            end else if (move_player != turn_r) begin
                                error_r      <= 1'b1;
                                error_code_r <= 2'd2;
                            end else if (full_s) begin
                                error_r      <= 1'b1;
                                error_code_r <= 2'd1;
                            end else begin
                                occupied_r[acc_idx_s] <= 1'b1;
                                owner_r[acc_idx_s]    <= move_player;
                                move_cnt_r   <= move_cnt_r + CNT_W'(1);
                                last_row_r   <= drop_row_s;
                                last_col_r   <= col_idx_s;
                                mover_r      <= move_player;
                                dir_r        <= 2'd0;
                                win_r        <= 1'b0;
                                state_r      <= CHECK;
                                move_ready_r <= 1'b0;
                                busy_r       <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (dir_r == 2'd3) begin
                            busy_r <= 1'b0;
                            if (win_r || hit_s) begin
                                winner_r    <= {mover_r, ~mover_r};
                                game_over_r <= 1'b1;
                                state_r     <= DONE;
                            end else if (move_cnt_r == CNT_W'(CELLS)) begin
                                winner_r    <= 2'b11;
                                game_over_r <= 1'b1;
                                state_r     <= DONE;
                            end else begin
                                turn_r       <= ~turn_r;
                                move_ready_r <= 1'b1;
                                state_r      <= PLAY;
                            end
                        end else begin
                            dir_r <= dir_r + 2'd1;
                            win_r <= win_r | hit_s;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign move_ready = move_ready_r;
    assign turn       = turn_r;
    assign occupied   = occupied_r;
    assign owner      = owner_r;
    assign winner     = winner_r;
    assign game_over  = game_over_r;
    assign busy       = busy_r;
    assign error      = error_r;
    assign error_code = error_code_r;
endmodule
